// File: rtl/gpu_pkg.sv
// Shared GPU constants: VRAM map, CPU register offsets, increment encodings.
package gpu_pkg;

  localparam int unsigned VRAM_ADDR_W = 15;

  localparam logic [VRAM_ADDR_W-1:0] TILEMAP_BASE = 15'h0000;
  localparam logic [VRAM_ADDR_W-1:0] COLOR_BASE   = 15'h2000;
  localparam logic [VRAM_ADDR_W-1:0] PATTERN_BASE = 15'h4000;

  localparam logic [2:0] REG_ADDR_LO = 3'd0;
  localparam logic [2:0] REG_ADDR_HI = 3'd1;
  localparam logic [2:0] REG_DATA    = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_FILL_LO = 3'd4;
  localparam logic [2:0] REG_FILL_HI = 3'd5;
  localparam logic [2:0] REG_FILL_GO = 3'd6;

  localparam logic [1:0] INCR_1   = 2'b00;
  localparam logic [1:0] INCR_8   = 2'b01;
  localparam logic [1:0] INCR_16  = 2'b10;
  localparam logic [1:0] INCR_128 = 2'b11;

  typedef enum logic {FillIdle, FillRun} fill_state_e;

  function automatic logic [7:0] incr_step(input logic [1:0] sel);
    logic [7:0] step;
    case (sel)
      INCR_1:  step = 8'd1;
      INCR_8:  step = 8'd8;
      INCR_16: step = 8'd16;
      default: step = 8'd128;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; push is refused when full even if a pop
// happens in the same cycle.
module gpu_sync_fifo #(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (PtrW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/vram_write_port.sv
// CPU register window that queues VRAM writes and drains them on arbiter grants.
// Optional block-fill engine enabled by defining BLOCK_FILL_EN.
module vram_write_port
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = VRAM_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        reg_sel,
  input  logic              reg_we,
  input  logic              reg_re,
  input  logic [7:0]        reg_wdata,
  output logic [7:0]        reg_rdata,
  output logic              vram_wr_req,
  input  logic              vram_wr_grant,
  output logic [ADDR_W-1:0] vram_wr_addr,
  output logic [7:0]        vram_wr_data,
  output logic              busy
);

  logic [ADDR_W-1:0]            r_cur_addr;
  logic [1:0]                   r_incr;
  logic                         r_overflow;
  logic [7:0]                   r_rdata;
  logic                         w_full;
  logic                         w_empty;
  logic [$clog2(FIFO_DEPTH):0]  w_count;
  logic                         w_data_wr;
  logic                         w_data_push;
  logic                         w_data_drop;
  logic                         w_fill_active;
  logic                         w_fill_push;
  logic [7:0]                   w_fill_val;
  logic [7:0]                   w_fill_rd;
  logic [7:0]                   w_rd_val;
  logic [ADDR_W-1:0]            w_step;
  logic [ADDR_W+7:0]            w_head;

  assign w_data_wr   = reg_we && (reg_sel == REG_DATA);
  assign w_data_push = w_data_wr && !w_full && !w_fill_active;
  assign w_data_drop = w_data_wr && (w_full || w_fill_active);
  assign w_step      = ADDR_W'(incr_step(r_incr));

`ifdef BLOCK_FILL_EN
  fill_state_e r_fill_state;
  logic [15:0] r_fill_len;
  logic [7:0]  r_fill_val;

  assign w_fill_active = (r_fill_state == FillRun);
  assign w_fill_push   = w_fill_active && !w_full;
  assign w_fill_val    = r_fill_val;

  always_comb begin
    w_fill_rd = 8'h00;
    if (reg_sel == REG_FILL_LO) w_fill_rd = r_fill_len[7:0];
    if (reg_sel == REG_FILL_HI) w_fill_rd = r_fill_len[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_state <= FillIdle;
      r_fill_len   <= 16'h0000;
      r_fill_val   <= 8'h00;
    end else begin
      case (r_fill_state)
        FillIdle: begin
          if (reg_we && reg_sel == REG_FILL_LO) r_fill_len[7:0]  <= reg_wdata;
          if (reg_we && reg_sel == REG_FILL_HI) r_fill_len[15:8] <= reg_wdata;
          if (reg_we && reg_sel == REG_FILL_GO && r_fill_len != 16'h0000) begin
            r_fill_state <= FillRun;
            r_fill_val   <= reg_wdata;
          end
        end
        default: begin
          // Stall while the queue is full; the engine never drops a fill word.
          if (!w_full) begin
            r_fill_len <= r_fill_len - 16'd1;
            if (r_fill_len == 16'd1) r_fill_state <= FillIdle;
          end
        end
      endcase
    end
  end
`else
  assign w_fill_active = 1'b0;
  assign w_fill_push   = 1'b0;
  assign w_fill_val    = 8'h00;
  assign w_fill_rd     = 8'h00;
`endif

  gpu_sync_fifo #(
    .WIDTH (ADDR_W + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_data_push || w_fill_push),
    .i_wdata ({r_cur_addr, (w_fill_active ? w_fill_val : reg_wdata)}),
    .i_pop   (vram_wr_req && vram_wr_grant),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_rd_val = 8'h00;
    case (reg_sel)
      REG_ADDR_LO: w_rd_val = r_cur_addr[7:0];
      REG_ADDR_HI: w_rd_val = 8'(r_cur_addr >> 8);
      REG_CTRL:    w_rd_val = {r_overflow, w_fill_active, w_full, w_empty, r_incr, 2'b00};
      default:     w_rd_val = w_fill_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr <= '0;
      r_incr     <= INCR_1;
      r_overflow <= 1'b0;
      r_rdata    <= 8'h00;
    end else begin
      if (w_data_push || w_fill_push) r_cur_addr <= r_cur_addr + w_step;
      if (w_data_drop) r_overflow <= 1'b1;
      if (reg_we) begin
        case (reg_sel)
          REG_ADDR_LO: r_cur_addr[7:0]        <= reg_wdata;
          REG_ADDR_HI: r_cur_addr[ADDR_W-1:8] <= reg_wdata[ADDR_W-9:0];
          REG_CTRL: begin
            r_incr <= reg_wdata[1:0];
            if (reg_wdata[7]) r_overflow <= 1'b0;
          end
          default: ;
        endcase
      end
      if (reg_re) r_rdata <= w_rd_val;
    end
  end

  // Masking with rst keeps a grant in the reset cycle from committing a stale head.
  assign vram_wr_req  = !w_empty && !rst;
  assign vram_wr_addr = w_head[ADDR_W+7:8];
  assign vram_wr_data = w_head[7:0];
  assign reg_rdata    = r_rdata;
  assign busy         = (w_count != '0) || w_fill_active;

endmodule

// File: tb/tb_vram_write_port.sv
// Directed self-checking bench for vram_write_port; VRAM writes are logged on req&&grant.
module tb_vram_write_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  reg_sel;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        vram_wr_req;
  logic        vram_wr_grant;
  logic [14:0] vram_wr_addr;
  logic [7:0]  vram_wr_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] wa[$];
  logic [7:0]  wd[$];
  logic        hold_v = 1'b0;
  logic [14:0] hold_a;
  logic [7:0]  hold_d;

  always #5 clk = ~clk;

  vram_write_port #(
    .ADDR_W     (15),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .reg_sel       (reg_sel),
    .reg_we        (reg_we),
    .reg_re        (reg_re),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .vram_wr_req   (vram_wr_req),
    .vram_wr_grant (vram_wr_grant),
    .vram_wr_addr  (vram_wr_addr),
    .vram_wr_data  (vram_wr_data),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (vram_wr_req && vram_wr_grant) begin
      wa.push_back(vram_wr_addr);
      wd.push_back(vram_wr_data);
    end
    if (hold_v && vram_wr_req) begin
      chk("hold_addr", 32'(vram_wr_addr), 32'(hold_a));
      chk("hold_data", 32'(vram_wr_data), 32'(hold_d));
    end
    hold_v = vram_wr_req && !vram_wr_grant;
    hold_a = vram_wr_addr;
    hold_d = vram_wr_data;
  end

  // All tasks start and end at a falling edge.
  task automatic wr(input logic [2:0] s, input logic [7:0] d);
    reg_we = 1'b1; reg_sel = s; reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] s, output logic [7:0] d);
    reg_re = 1'b1; reg_sel = s;
    @(negedge clk);
    reg_re = 1'b0;
    d = reg_rdata;
  endtask

  task automatic cyc(input logic we, input logic [7:0] d, input logic g);
    reg_we = we; reg_sel = 3'd2; reg_wdata = d; vram_wr_grant = g;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] r;

  initial begin
    rst = 1'b1; reg_sel = 3'd0; reg_we = 1'b0; reg_re = 1'b0; reg_wdata = 8'h00;
    vram_wr_grant = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    chk("rst_req", 32'(vram_wr_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rdata", 32'(reg_rdata), 32'h0);
    rd(3'd3, r); chk("rst_status", 32'(r), 32'h10);

    // Two writes at COLOR_BASE, grant held high
    vram_wr_grant = 1'b1;
    wr(3'd0, 8'h00); wr(3'd1, 8'h20);
    wr(3'd2, 8'hAA); wr(3'd2, 8'hBB);
    idle(4);
    chk("t1_count", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("t1_a0", 32'(wa[0]), 32'h2000); chk("t1_d0", 32'(wd[0]), 32'hAA);
      chk("t1_a1", 32'(wa[1]), 32'h2001); chk("t1_d1", 32'(wd[1]), 32'hBB);
    end
    chk("t1_req_low", 32'(vram_wr_req), 32'h0);
    chk("t1_busy_low", 32'(busy), 32'h0);
    rd(3'd0, r); chk("t1_addr_lo", 32'(r), 32'h02);
    rd(3'd1, r); chk("t1_addr_hi", 32'(r), 32'h20);
    rd(3'd2, r); chk("t1_data_rd", 32'(r), 32'h00);
    // Simultaneous write and read returns the pre-write value
    reg_re = 1'b1;
    wr(3'd0, 8'h55);
    reg_re = 1'b0;
    chk("t1_rw_old", 32'(reg_rdata), 32'h02);
    rd(3'd0, r); chk("t1_rw_new", 32'(r), 32'h55);

    // Overflow with grant held low
    vram_wr_grant = 1'b0;
    wa.delete(); wd.delete();
    wr(3'd0, 8'h00); wr(3'd1, 8'h00);
    for (int i = 0; i < 9; i++) wr(3'd2, 8'(8'h10 + i));
    rd(3'd3, r); chk("t2_status_full", 32'(r), 32'hA0);
    rd(3'd0, r); chk("t2_addr_adv8", 32'(r), 32'h08);
    chk("t2_head_addr", 32'(vram_wr_addr), 32'h0000);
    chk("t2_head_data", 32'(vram_wr_data), 32'h10);
    chk("t2_busy", 32'(busy), 32'h1);
    wr(3'd3, 8'h80);
    rd(3'd3, r); chk("t2_ovf_clear", 32'(r), 32'h20);
    vram_wr_grant = 1'b1;
    idle(12);
    chk("t2_count", 32'(wa.size()), 32'd8);
    if (wa.size() == 8) begin
      chk("t2_last_a", 32'(wa[7]), 32'h0007);
      chk("t2_last_d", 32'(wd[7]), 32'h17);
    end

    // Address wrap with +16
    wa.delete(); wd.delete();
    wr(3'd0, 8'hFF); wr(3'd1, 8'h7F); wr(3'd3, 8'h02);
    wr(3'd2, 8'h01); wr(3'd2, 8'h02);
    idle(4);
    chk("t3_count", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("t3_a0", 32'(wa[0]), 32'h7FFF);
      chk("t3_a1", 32'(wa[1]), 32'h000F);
    end
    rd(3'd3, r); chk("t3_status", 32'(r), 32'h18);

    // Grant 1-of-4 during pushes
    wr(3'd3, 8'h00);
    vram_wr_grant = 1'b0;
    wr(3'd0, 8'h00); wr(3'd1, 8'h01);
    wa.delete(); wd.delete();
    for (int i = 0; i < 24; i++) cyc(i < 4, 8'(8'h31 + i), (i % 4) == 3);
    chk("t4_count", 32'(wa.size()), 32'd4);
    if (wa.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t4_addr", 32'(wa[i]), 32'(15'h0100 + i));
        chk("t4_data", 32'(wd[i]), 32'(8'h31 + i));
      end
    end

    // Reset with 5 queued entries and a grant in the reset cycle
    vram_wr_grant = 1'b0;
    for (int i = 0; i < 5; i++) wr(3'd2, 8'(8'h60 + i));
    chk("t5_pre_req", 32'(vram_wr_req), 32'h1);
    wa.delete(); wd.delete();
    rst = 1'b1; vram_wr_grant = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t5_req", 32'(vram_wr_req), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    idle(4);
    chk("t5_no_writes", 32'(wa.size()), 32'd0);
    rd(3'd3, r); chk("t5_status", 32'(r), 32'h10);
    rd(3'd0, r); chk("t5_addr_lo", 32'(r), 32'h00);
    rd(3'd1, r); chk("t5_addr_hi", 32'(r), 32'h00);

`ifdef BLOCK_FILL_EN
    wa.delete(); wd.delete();
    wr(3'd0, 8'h00); wr(3'd1, 8'h40);
    wr(3'd4, 8'h14); wr(3'd5, 8'h00);
    rd(3'd4, r); chk("t6_len_lo", 32'(r), 32'h14);
    wr(3'd6, 8'hFF);
    chk("t6_busy", 32'(busy), 32'h1);
    idle(30);
    chk("t6_count", 32'(wa.size()), 32'd20);
    if (wa.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        chk("t6_addr", 32'(wa[i]), 32'(15'h4000 + i));
        chk("t6_data", 32'(wd[i]), 32'hFF);
      end
    end
    rd(3'd3, r); chk("t6_status", 32'(r), 32'h10);
    rd(3'd0, r); chk("t6_addr_lo", 32'(r), 32'h14);
    // FILL_GO with zero length does nothing
    wa.delete(); wd.delete();
    wr(3'd6, 8'h11);
    chk("t6_zero_busy", 32'(busy), 32'h0);
    idle(3);
    chk("t6_zero_count", 32'(wa.size()), 32'd0);
`else
    wr(3'd4, 8'h05);
    rd(3'd4, r); chk("t6_fill_lo_rd", 32'(r), 32'h00);
    wr(3'd6, 8'hFF);
    chk("t6_go_busy", 32'(busy), 32'h0);
    rd(3'd3, r); chk("t6_status", 32'(r), 32'h10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
